// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one bit per clock.
// One bit cell (d = a ^ b ^ bf) feeds a registered borrow. Results are
// presented WIDTH+1 cycles after start.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output.
//
// Handshake: start is sampled on each rising clk. It is accepted in IDLE or
// DONE; the accepting edge captures A and B and raises busy. While busy is
// high, start is ignored. done is a one-cycle pulse in the cycle after the
// final shift edge. difference/borrow(/overflow) load only on that edge and
// hold until the next completion or reset.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             bf;
  logic [CW-1:0]    cnt;

  logic             a_bit, b_bit, d_bit, bf_next;
  logic [WIDTH-1:0] diff_next;
  logic             accept, last;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb;
`endif

  // Bit cell: difference bit and next borrow from the current LSBs.
  always_comb begin
    a_bit     = a_sr[0];
    b_bit     = b_sr[0];
    d_bit     = a_bit ^ b_bit ^ bf;
    bf_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bf);
    // Shift the new bit in at the MSB; the old LSB falls off.
    diff_next = WIDTH'({d_bit, diff_sr} >> 1);
  end

  // Next-state logic and status outputs decoded from the state register.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, serial shifting and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      bf         <= 1'b0;
      cnt        <= '0;
      difference <= '0;
      borrow     <= 1'b0;
    end else if (accept) begin
      a_sr    <= A;
      b_sr    <= B;
      diff_sr <= '0;
      bf      <= 1'b0;
      cnt     <= '0;
    end else if (state_q == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= diff_next;
      bf      <= bf_next;
      // cnt stops at WIDTH-1, so it never wraps.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        difference <= diff_next;
        borrow     <= bf_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Signed overflow: operand signs differ and the result sign differs from A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
    end else if (last) begin
      overflow <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed cases plus random operands,
// checked against an arithmetic reference model through an expected queue.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, borrow;
  logic [W-1:0] difference;
  logic [1:0]   dbg_state;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done_cyc = 0;

  // Expected {overflow, borrow, difference} per accepted operation.
  logic [W+1:0] exp_q[$];
  logic [W-1:0] held_diff;
  logic         held_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow     (borrow),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int          sa, sb, r;
    logic [W-1:0] d;
    logic        brw, ovf;
    d   = W'(int'(a) - int'(b));
    brw = (a < b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = sa - sb;
    ovf = (r > 127) || (r < -128);
    return {ovf, brw, d};
  endfunction

  // Driver: call at a negedge. Runs one operation to its done pulse.
  // hold keeps start high afterwards; inject pulses start (A=0) mid-shift.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit inject, input bit check_gap);
    int cycles, busy_cnt;
    logic [W+1:0] e;
    A = a; B = b; start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    cycles = 0; busy_cnt = 0;
    while (!done && cycles < 50) begin
      @(negedge clk);
      cycles++;
      if (busy) begin
        busy_cnt++;
        check("hold_diff", difference, held_diff);
        check("hold_borrow", borrow, held_borrow);
      end
      if (inject && cycles == 3) begin A = '0; B = 8'h11; start = 1'b1; end
      if (inject && cycles == 4) start = 1'b0;
    end
    check("done_seen", done, 1'b1);
    check("latency", cycles, 9);
    check("busy_cycles", busy_cnt, 8);
    if (check_gap) check("done_gap", cyc - last_done_cyc, 9);
    last_done_cyc = cyc;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("difference", difference, e[W-1:0]);
      check("borrow", borrow, e[W]);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("overflow", overflow, e[W+1]);
`endif
      held_diff   = e[W-1:0];
      held_borrow = e[W];
    end
    if (!hold) begin
      @(negedge clk);
      check("done_pulse", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("post_diff", difference, held_diff);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    held_diff = '0; held_borrow = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", difference, 0);
    check("rst_borrow", borrow, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", overflow, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(8'h05, 8'h03, 0, 0, 0);
    run_op(8'h03, 8'h05, 0, 0, 0);
    run_op(8'h00, 8'h00, 0, 0, 0);
    run_op(8'hFF, 8'h01, 0, 1, 0);
    run_op(8'h80, 8'h01, 0, 0, 0);
    run_op(8'h7F, 8'hFF, 0, 0, 0);

    // Start held high: back-to-back operations, done pulses 9 apart.
    run_op(8'h10, 8'h01, 1, 0, 0);
    run_op(8'h01, 8'h10, 0, 0, 1);

    // Reset mid-operation.
    A = 8'hAA; B = 8'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", difference, 0);
    check("abort_borrow", borrow, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    held_diff = '0; held_borrow = 1'b0;
    @(negedge clk);
    run_op(8'hAA, 8'h55, 0, 0, 0);

    // Random operands.
    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom), W'($urandom), 0, ($urandom_range(0, 3) == 0), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
